// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for pipeline stage registers.
//   - CTRL_* : bit positions inside the control bundle {memwrite, memread,
//              regwrite, regsrc}. Every stage that decodes ctrl uses these.
//   - stage_payload_t : field layout of one stage entry at the core's default
//              widths. Field order (ctrl, rd, alu, sdata, f3) is also the
//              order used when a stage packs its payload into a flat vector.
//   - payload_width() : flat payload width for arbitrary field widths, so
//              parametrised stages stay consistent with the struct layout.
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Control bundle bit indices
    localparam int CTRL_REGSRC   = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;

    // Default field widths of the core
    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 4;
    localparam int RD_W_DEF   = 5;
    localparam int F3_W_DEF   = 3;

    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [RD_W_DEF-1:0]   rd;
        logic [XLEN_DEF-1:0]   alu;
        logic [XLEN_DEF-1:0]   sdata;
        logic [F3_W_DEF-1:0]   f3;
    } stage_payload_t;

    localparam int STAGE_PAYLOAD_W = $bits(stage_payload_t);

    // Flat payload width for a stage built with non-default field widths.
    function automatic int payload_width(input int ctrl_w, input int rd_w,
                                         input int xlen, input int f3_w);
        return ctrl_w + rd_w + 2 * xlen + f3_w;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One pipeline entry: a payload register plus its valid bit.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears valid and data)
//   load        : capture d and mark valid
//   unload      : mark invalid, payload kept (no toggling on bubbles)
//   clear       : flush; marks invalid, overrides load and unload
//   d           : payload to capture
//   valid, q    : registered valid bit and payload
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (clear) begin
            // Data intentionally left stale; only the valid bit matters.
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= d;
        end else if (unload) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign q     = data_reg;

endmodule : pipe_slot

// File: rtl/ex_mem_stage_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_stage_reg
// EX/MEM pipeline register with valid/ready handshake, flush, optional
// 2-entry skid buffer and a saturating back-pressure counter.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream handshake (accept = in_valid && in_ready)
//   in_ctrl..in_f3        : payload from EX
//   flush                 : kill every held entry and any same-cycle accept
//   out_valid / out_ready : downstream handshake (drain = out_valid && out_ready)
//   out_ctrl..out_f3      : payload to MEM; out_ctrl forced to 0 on bubbles
//   stall_cnt             : cycles with out_valid && !out_ready, saturating
// SKID=1: main slot M plus skid slot S, in_ready = !S.valid (registered).
// SKID=0: main slot only, in_ready = !out_valid || out_ready (combinational).
// -----------------------------------------------------------------------------
module ex_mem_stage_reg
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4,
    parameter int RD_W   = 5,
    parameter int F3_W   = 3,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_sdata,
    input  logic [F3_W-1:0]   in_f3,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_sdata,
    output logic [F3_W-1:0]   out_f3,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = payload_width(CTRL_W, RD_W, XLEN, F3_W);

    // Field offsets inside the flat payload {ctrl, rd, alu, sdata, f3}
    localparam int F3_LO    = 0;
    localparam int SDATA_LO = F3_LO + F3_W;
    localparam int ALU_LO   = SDATA_LO + XLEN;
    localparam int RD_LO    = ALU_LO + XLEN;
    localparam int CTRL_LO  = RD_LO + RD_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0] in_payload;
    logic [PW-1:0] m_d;
    logic [PW-1:0] m_q;
    logic          m_valid;
    logic          m_load;
    logic          m_unload;
    logic          accept;
    logic          drain;
    logic [CNT_W-1:0] stall_cnt_reg;

    assign in_payload = {in_ctrl, in_rd, in_alu, in_sdata, in_f3};
    assign accept     = in_valid && in_ready;
    assign drain      = m_valid && out_ready;

    pipe_slot #(.W(PW)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (m_load),
        .unload (m_unload),
        .clear  (flush),
        .d      (m_d),
        .valid  (m_valid),
        .q      (m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic          s_valid;
            logic [PW-1:0] s_q;
            logic          s_load;
            logic          s_unload;

            // in_ready comes straight from a flop: no path from out_ready.
            assign in_ready = !s_valid;

            // M refills from S first so S can never overtake M.
            // S is only ever valid while M is valid, so when M is empty
            // the incoming entry goes directly to M.
            assign m_load   = (drain && s_valid) ||
                              (accept && (!m_valid || drain));
            assign m_d      = s_valid ? s_q : in_payload;
            assign m_unload = drain && !m_load;

            // Park an accepted entry in S only when M is occupied and stuck.
            assign s_load   = accept && m_valid && !drain;
            assign s_unload = drain && s_valid;

            pipe_slot #(.W(PW)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (s_load),
                .unload (s_unload),
                .clear  (flush),
                .d      (in_payload),
                .valid  (s_valid),
                .q      (s_q)
            );
        end else begin : g_single
            assign in_ready = !m_valid || out_ready;
            assign m_load   = accept;
            assign m_d      = in_payload;
            assign m_unload = drain && !accept;
        end
    endgenerate

    // Back-pressure profiling counter; flush deliberately does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (m_valid && !out_ready && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

    // Bubbles carry zero control so MEM never writes or accesses on them.
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_q[CTRL_LO +: CTRL_W] : '0;
    assign out_rd    = m_q[RD_LO    +: RD_W];
    assign out_alu   = m_q[ALU_LO   +: XLEN];
    assign out_sdata = m_q[SDATA_LO +: XLEN];
    assign out_f3    = m_q[F3_LO    +: F3_W];

endmodule : ex_mem_stage_reg
